// File: rtl/calib_ram_pkg.sv
// Shared types and sizes for the calibration RAM responder: FSM state encoding and default widths.
package calib_ram_pkg;

  localparam int CALIB_ADDR_W = 9;
  localparam int CALIB_DATA_W = 16;
  localparam int CALIB_WAIT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    S_RD,
    S_WAIT,
    S_ACK,
    H_RD,
    H_ACK
  } calib_state_t;

endpackage

// File: rtl/calib_ram_sp.sv
// Inferred single-port synchronous RAM, one-cycle registered read (old data on same-address write).
// INIT_FILE is handed to the vendor RAM inference as a .mif preload; empty leaves contents undefined.
module calib_ram_sp #(
  parameter int ADDR_W    = 9,
  parameter int WIDTH     = 16,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  (* ram_init_file = INIT_FILE *) logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/calib_ram_responder.sv
// Sensor/host Avalon-MM slaves sharing one calibration RAM; sensor read acks in cycle 2+WAIT_CYCLES, host read/write in 2/1.
// Sensor has strict priority, every ack returns through IDLE. Define CALIB_RAM_PARITY_EN for stored even parity + sticky parity_err.
module calib_ram_responder
  import calib_ram_pkg::*;
#(
  parameter int ADDR_W      = CALIB_ADDR_W,
  parameter int DATA_W      = CALIB_DATA_W,
  parameter int WAIT_CYCLES = 0,
  parameter     INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_address,
  input  logic              s_read,
  output logic [DATA_W-1:0] s_readdata,
  output logic              s_waitrequest,
  input  logic [ADDR_W-1:0] h_address,
  input  logic              h_read,
  input  logic              h_write,
  input  logic [31:0]       h_writedata,
  output logic [31:0]       h_readdata,
  output logic              h_waitrequest,
  output logic              parity_err
);

`ifdef CALIB_RAM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  calib_state_t            state;
  logic [CALIB_WAIT_W-1:0] wait_cnt;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [RAM_W-1:0]        ram_wdata;
  logic [RAM_W-1:0]        ram_rdata;
  logic [DATA_W-1:0]       wr_data;
  logic [DATA_W-1:0]       rd_data;
  logic                    par_bad;
  logic                    unused_wr_hi;

  assign wr_data      = h_writedata[DATA_W-1:0];
  assign rd_data      = ram_rdata[DATA_W-1:0];
  assign unused_wr_hi = ^h_writedata[31:DATA_W];

`ifdef CALIB_RAM_PARITY_EN
  assign ram_wdata = {^wr_data, wr_data};
  assign par_bad   = ^ram_rdata;
`else
  assign ram_wdata = wr_data;
  assign par_bad   = 1'b0;
`endif

  // The RAM port is only steered in IDLE; other states leave it reading harmlessly.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = h_address;
    if (state == IDLE && !reset) begin
      if (s_read) begin
        ram_addr = s_address;
      end else if (h_write) begin
        ram_we = 1'b1;
      end
    end
  end

  calib_ram_sp #(
    .ADDR_W   (ADDR_W),
    .WIDTH    (RAM_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      s_waitrequest <= 1'b1;
      h_waitrequest <= 1'b1;
      s_readdata    <= '0;
      h_readdata    <= '0;
      parity_err    <= 1'b0;
    end else begin
      s_waitrequest <= 1'b1;
      h_waitrequest <= 1'b1;
      case (state)
        IDLE: begin
          if (s_read) begin
            state <= S_RD;
          end else if (h_write) begin
            state         <= H_ACK;
            h_waitrequest <= 1'b0;
          end else if (h_read) begin
            state <= H_RD;
          end
        end
        S_RD: begin
          s_readdata <= rd_data;
          parity_err <= parity_err | par_bad;
          if (WAIT_CYCLES == 0) begin
            state         <= S_ACK;
            s_waitrequest <= 1'b0;
          end else begin
            wait_cnt <= CALIB_WAIT_W'(WAIT_CYCLES);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == CALIB_WAIT_W'(1)) begin
            state         <= S_ACK;
            s_waitrequest <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        H_RD: begin
          h_readdata    <= 32'(rd_data);
          parity_err    <= parity_err | par_bad;
          state         <= H_ACK;
          h_waitrequest <= 1'b0;
        end
        S_ACK:   state <= IDLE;
        H_ACK:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calib_ram_responder.sv
// Bench for calib_ram_responder: directed table, contention/reset/wait-state sequences, randomized ops vs array model.
module tb_calib_ram_responder;

  localparam int LIMIT = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  s_address     [2];
  logic        s_read        [2];
  logic [15:0] s_readdata    [2];
  logic        s_waitrequest [2];
  logic [8:0]  h_address     [2];
  logic        h_read        [2];
  logic        h_write       [2];
  logic [31:0] h_writedata   [2];
  logic [31:0] h_readdata    [2];
  logic        h_waitrequest [2];
  logic        parity_err    [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calib_ram_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .s_address(s_address[0]), .s_read(s_read[0]), .s_readdata(s_readdata[0]),
    .s_waitrequest(s_waitrequest[0]),
    .h_address(h_address[0]), .h_read(h_read[0]), .h_write(h_write[0]),
    .h_writedata(h_writedata[0]), .h_readdata(h_readdata[0]),
    .h_waitrequest(h_waitrequest[0]), .parity_err(parity_err[0])
  );

  calib_ram_responder #(.WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset),
    .s_address(s_address[1]), .s_read(s_read[1]), .s_readdata(s_readdata[1]),
    .s_waitrequest(s_waitrequest[1]),
    .h_address(h_address[1]), .h_read(h_read[1]), .h_write(h_write[1]),
    .h_writedata(h_writedata[1]), .h_readdata(h_readdata[1]),
    .h_waitrequest(h_waitrequest[1]), .parity_err(parity_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Cycle 0 is the cycle the request is first driven; returns the first cycle with waitrequest low.
  task automatic sensor_op(input int i, input logic [8:0] a,
                           output logic [15:0] rd, output int cyc, output logic wr_after);
    s_address[i] = a;
    s_read[i]    = 1'b1;
    cyc = -1;
    rd  = '0;
    for (int c = 0; c < LIMIT; c++) begin
      @(negedge clk);
      if (!s_waitrequest[i]) begin
        cyc = c;
        rd  = s_readdata[i];
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_read[i] = 1'b0;
    @(negedge clk);
    wr_after = s_waitrequest[i];
    @(posedge clk); #1;
  endtask

  task automatic host_op(input int i, input bit wr, input logic [8:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output int cyc, output logic wr_after);
    h_address[i]   = a;
    h_writedata[i] = wd;
    h_write[i]     = wr;
    h_read[i]      = !wr;
    cyc = -1;
    rd  = '0;
    for (int c = 0; c < LIMIT; c++) begin
      @(negedge clk);
      if (!h_waitrequest[i]) begin
        cyc = c;
        rd  = h_readdata[i];
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    h_write[i] = 1'b0;
    h_read[i]  = 1'b0;
    @(negedge clk);
    wr_after = h_waitrequest[i];
    @(posedge clk); #1;
  endtask

  // op: 0 host write, 1 host read, 2 sensor read
  typedef struct {
    int          op;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [10];

  logic [15:0] model_mem [512];
  logic [8:0]  written_q [$];

  initial begin
    logic [15:0] sd, sd2;
    logic [31:0] hd;
    int          cyc, cyc2;
    logic        wa, wa2;

    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sd, sd2;
    logic [31:0] hd;
    int          cyc, cyc2;
    logic        wa, wa2;

    for (int i = 0; i < 2; i++) begin
      s_address[i] = '0; s_read[i] = 1'b0;
      h_address[i] = '0; h_read[i] = 1'b0; h_write[i] = 1'b0; h_writedata[i] = '0;
    end

    vecs[0] = '{0, 9'd5,   32'h0000_1234, 32'h0,         1};
    vecs[1] = '{2, 9'd5,   32'h0,         32'h0000_1234, 2};
    vecs[2] = '{0, 9'd2,   32'hFFFF_8001, 32'h0,         1};
    vecs[3] = '{1, 9'd2,   32'h0,         32'h0000_8001, 2};
    vecs[4] = '{0, 9'h1FF, 32'h1234_A5A5, 32'h0,         1};
    vecs[5] = '{2, 9'h1FF, 32'h0,         32'h0000_A5A5, 2};
    vecs[6] = '{1, 9'd5,   32'h0,         32'h0000_1234, 2};
    vecs[7] = '{0, 9'd0,   32'hABCD_0000, 32'h0,         1};
    vecs[8] = '{2, 9'd0,   32'h0,         32'h0000_0000, 2};
    vecs[9] = '{1, 9'h1FF, 32'h0,         32'h0000_A5A5, 2};

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_wait", 32'(s_waitrequest[0]), 32'd1);
    check("rst_h_wait", 32'(h_waitrequest[0]), 32'd1);
    check("rst_s_data", 32'(s_readdata[0]), 32'd0);
    check("rst_h_data", h_readdata[0], 32'd0);
    check("rst_parity", 32'(parity_err[0]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 10; k++) begin
      if (vecs[k].op == 2) begin
        sensor_op(0, vecs[k].addr, sd, cyc, wa);
        check($sformatf("vec%0d_s_data", k), 32'(sd), vecs[k].exp_data);
        check($sformatf("vec%0d_s_wait_after", k), 32'(wa), 32'd1);
      end else begin
        host_op(0, vecs[k].op == 0, vecs[k].addr, vecs[k].wdata, hd, cyc, wa);
        if (vecs[k].op == 1) check($sformatf("vec%0d_h_data", k), hd, vecs[k].exp_data);
        check($sformatf("vec%0d_h_wait_after", k), 32'(wa), 32'd1);
      end
      check($sformatf("vec%0d_ack_cycle", k), 32'(cyc), 32'(vecs[k].exp_cyc));
    end
    check("s_data_held", 32'(s_readdata[0]), 32'h0000_0000);
    check("h_data_held", h_readdata[0], 32'h0000_A5A5);

    // Sensor and host write in the same cycle: sensor first, host served in the next free IDLE.
    host_op(0, 1'b1, 9'd7, 32'h0000_0055, hd, cyc, wa);
    fork
      sensor_op(0, 9'd7, sd, cyc, wa);
      host_op(0, 1'b1, 9'd7, 32'h0000_00AA, hd, cyc2, wa2);
    join
    check("contend_s_data", 32'(sd), 32'h0000_0055);
    check("contend_s_cycle", 32'(cyc), 32'd2);
    check("contend_h_cycle", 32'(cyc2), 32'd4);
    host_op(0, 1'b0, 9'd7, 32'h0, hd, cyc, wa);
    check("contend_h_readback", hd, 32'h0000_00AA);

    // Wait-state instance.
    host_op(1, 1'b1, 9'h1FF, 32'h0000_BEEF, hd, cyc, wa);
    check("w3_write_cycle", 32'(cyc), 32'd1);
    sensor_op(1, 9'h1FF, sd, cyc, wa);
    check("w3_s_cycle", 32'(cyc), 32'd5);
    check("w3_s_data", 32'(sd), 32'h0000_BEEF);
    check("w3_s_wait_after", 32'(wa), 32'd1);

`ifdef CALIB_RAM_PARITY_EN
    host_op(0, 1'b1, 9'd9, 32'h0000_1357, hd, cyc, wa);
    check("par_clean", 32'(parity_err[0]), 32'd0);
    dut0.u_ram.mem[9] = dut0.u_ram.mem[9] ^ 17'h1_0000;
    sensor_op(0, 9'd9, sd, cyc, wa);
    check("par_data", 32'(sd), 32'h0000_1357);
    check("par_set", 32'(parity_err[0]), 32'd1);
    sensor_op(0, 9'd5, sd, cyc, wa);
    check("par_sticky", 32'(parity_err[0]), 32'd1);
`else
    check("par_tied_zero", 32'(parity_err[0]), 32'd0);
`endif

    // Reset while in S_RD: no acknowledge, outputs back to reset values.
    s_address[0] = 9'd5;
    s_read[0]    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_no_ack_c1", 32'(s_waitrequest[0]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_no_ack_c2", 32'(s_waitrequest[0]), 32'd1);
    check("midrst_s_data", 32'(s_readdata[0]), 32'd0);
    check("midrst_h_data", h_readdata[0], 32'd0);
    check("midrst_h_wait", 32'(h_waitrequest[0]), 32'd1);
    check("midrst_parity", 32'(parity_err[0]), 32'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    s_read[0] = 1'b0;
    @(posedge clk); #1;
    sensor_op(0, 9'd5, sd, cyc, wa);
    check("reissue_cycle", 32'(cyc), 32'd2);
    check("reissue_data", 32'(sd), 32'h0000_1234);

    // Randomized traffic against an array model.
    for (int n = 0; n < 80; n++) begin
      int          op;
      logic [8:0]  a;
      logic [31:0] wd;
      op = $urandom_range(0, 2);
      if (written_q.size() == 0) op = 0;
      if (op == 0) begin
        a  = 9'($urandom_range(0, 511));
        wd = $urandom;
        host_op(0, 1'b1, a, wd, hd, cyc, wa);
        model_mem[a] = wd[15:0];
        written_q.push_back(a);
        check($sformatf("rnd%0d_w_cycle", n), 32'(cyc), 32'd1);
      end else begin
        a = written_q[$urandom_range(0, written_q.size() - 1)];
        if (op == 1) begin
          host_op(0, 1'b0, a, 32'h0, hd, cyc, wa);
          check($sformatf("rnd%0d_h_data", n), hd, {16'h0, model_mem[a]});
        end else begin
          sensor_op(0, a, sd, cyc, wa);
          check($sformatf("rnd%0d_s_data", n), 32'(sd), 32'(model_mem[a]));
        end
        check($sformatf("rnd%0d_r_cycle", n), 32'(cyc), 32'd2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
